// File: rtl/cnt_arbiter_if.sv
// cnt_arbiter_if: request/grant/counter bundle shared by two requesters and the arbiter.
interface cnt_arbiter_if #(parameter int WIDTH = 5);
  logic req0, req1, pause, gnt0, gnt1, done0, done1, busy;
  logic [WIDTH-1:0] len0, len1, cnt_out;
  modport master(output req0, req1, len0, len1, pause, input gnt0, gnt1, done0, done1, busy, cnt_out);
  modport slave(input req0, req1, len0, len1, pause, output gnt0, gnt1, done0, done1, busy, cnt_out);
endinterface

// File: rtl/cnt_arbiter.sv
// cnt_arbiter: round-robin arbiter lending one interval counter to two requesters.
module cnt_arbiter #(parameter int WIDTH = 5) (
  input logic clk,
  input logic rst,
  cnt_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic owner, rr, gnt0, gnt1, done0, done1, busy;
  logic [WIDTH-1:0] cnt, len_q;
  logic pick, own_req;
  logic [WIDTH-1:0] len_sel;
  // a lone requester wins outright; rr only breaks ties
  assign pick = (bus.req0 && bus.req1) ? rr : bus.req1;
  assign len_sel = pick ? bus.len1 : bus.len0;
  assign own_req = owner ? bus.req1 : bus.req0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      rr <= 1'b0;
      cnt <= '0;
      len_q <= '0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: if (bus.req0 || bus.req1) begin
          owner <= pick;
          len_q <= len_sel;
          cnt <= '0;
          busy <= 1'b1;
          state <= (len_sel != '0) ? RUN : DONE;
          gnt0 <= (len_sel != '0) && !pick;
          gnt1 <= (len_sel != '0) && pick;
          done0 <= (len_sel == '0) && !pick;
          done1 <= (len_sel == '0) && pick;
        end
        RUN: if (!own_req) begin
          state <= IDLE;
          rr <= ~owner;
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          busy <= 1'b0;
        end else if (!bus.pause) begin
          if (cnt == len_q - 1'b1) begin
            state <= DONE;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done0 <= !owner;
            done1 <= owner;
          end else cnt <= cnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          rr <= ~owner;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;
  assign bus.done0 = done0;
  assign bus.done1 = done1;
  assign bus.busy = busy;
  assign bus.cnt_out = cnt;
endmodule

// File: tb/tb_cnt_arbiter.sv
// tb_cnt_arbiter: directed scenarios for cnt_arbiter with hand-derived cycle expectations.
module tb_cnt_arbiter;
  logic clk = 1'b0;
  logic rst;
  int vecs = 0;
  int errs = 0;
  cnt_arbiter_if #(.WIDTH(5)) bus();
  cnt_arbiter #(.WIDTH(5)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req0 = 0; bus.req1 = 0; bus.len0 = '0; bus.len1 = '0; bus.pause = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    tick;
    tick;
    vecs++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b0) begin
      errs++; $display("FAIL reset_outs got %b want 00000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy});
    end
    vecs++;
    if (bus.cnt_out !== 5'd0 || dut.rr !== 1'b0) begin
      errs++; $display("FAIL reset_state got cnt=%0d rr=%b want cnt=0 rr=0", bus.cnt_out, dut.rr);
    end
    rst = 0;
  endtask

  task automatic test_single;
    bus.req0 = 1; bus.len0 = 5'd4;
    for (int i = 0; i < 4; i++) begin
      tick;
      vecs++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.busy} !== 4'b1001 || bus.cnt_out !== 5'(i)) begin
        errs++; $display("FAIL single_run[%0d] got g0g1d0b=%b cnt=%0d want 1001 cnt=%0d", i, {bus.gnt0, bus.gnt1, bus.done0, bus.busy}, bus.cnt_out, i);
      end
      bus.len0 = 5'd1;
    end
    tick;
    vecs++;
    if ({bus.gnt0, bus.done0, bus.done1, bus.busy} !== 4'b0101) begin
      errs++; $display("FAIL single_done got g0d0d1b=%b want 0101", {bus.gnt0, bus.done0, bus.done1, bus.busy});
    end
    bus.req0 = 0;
    tick;
    vecs++;
    if ({bus.done0, bus.busy} !== 2'b00 || bus.cnt_out !== 5'd3) begin
      errs++; $display("FAIL single_idle got d0b=%b cnt=%0d want 00 cnt=3", {bus.done0, bus.busy}, bus.cnt_out);
    end
  endtask

  task automatic test_contention;
    logic [3:0] seq [11];
    seq = '{4'b1000, 4'b1000, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 4'b0000, 4'b1000, 4'b1000, 4'b0010};
    test_reset;
    bus.req0 = 1; bus.req1 = 1; bus.len0 = 5'd2; bus.len1 = 5'd2;
    for (int i = 0; i < 11; i++) begin
      tick;
      vecs++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== seq[i]) begin
        errs++; $display("FAIL contention[%0d] got g0g1d0d1=%b want %b", i, {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, seq[i]);
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    tick;
    vecs++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b0 || dut.rr !== 1'b1) begin
      errs++; $display("FAIL contention_end got outs=%b rr=%b want 00000 rr=1", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, dut.rr);
    end
  endtask

  task automatic test_pause;
    logic [4:0] pv;
    logic [4:0] cv [5];
    pv = 5'b00110;
    cv = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd2};
    bus.req1 = 1; bus.len1 = 5'd3;
    tick;
    bus.len1 = 5'd1; bus.req0 = 1; bus.len0 = 5'd2;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if ({bus.gnt0, bus.gnt1, bus.done1} !== 3'b010 || bus.cnt_out !== cv[i]) begin
        errs++; $display("FAIL pause[%0d] got g0g1d1=%b cnt=%0d want 010 cnt=%0d", i, {bus.gnt0, bus.gnt1, bus.done1}, bus.cnt_out, cv[i]);
      end
      bus.pause = pv[i];
      tick;
    end
    vecs++;
    if ({bus.gnt1, bus.done0, bus.done1, bus.cnt_out} !== {3'b001, 5'd2}) begin
      errs++; $display("FAIL pause_done got g1d0d1=%b cnt=%0d want 001 cnt=2", {bus.gnt1, bus.done0, bus.done1}, bus.cnt_out);
    end
    bus.req0 = 0; bus.req1 = 0;
    tick;
    vecs++;
    if ({bus.done1, bus.busy} !== 2'b00 || dut.rr !== 1'b0) begin
      errs++; $display("FAIL pause_idle got d1b=%b rr=%b want 00 rr=0", {bus.done1, bus.busy}, dut.rr);
    end
  endtask

  task automatic test_zero_abort;
    bus.req0 = 1; bus.len0 = 5'd0;
    tick;
    vecs++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.busy} !== 4'b0011) begin
      errs++; $display("FAIL zero_done got g0g1d0b=%b want 0011", {bus.gnt0, bus.gnt1, bus.done0, bus.busy});
    end
    bus.req0 = 0;
    tick;
    vecs++;
    if ({bus.gnt0, bus.done0, bus.busy} !== 3'b000 || dut.rr !== 1'b1) begin
      errs++; $display("FAIL zero_idle got g0d0b=%b rr=%b want 000 rr=1", {bus.gnt0, bus.done0, bus.busy}, dut.rr);
    end
    bus.req1 = 1; bus.len1 = 5'd6;
    for (int i = 0; i < 3; i++) begin
      tick;
      vecs++;
      if ({bus.gnt1, bus.busy} !== 2'b11 || bus.cnt_out !== 5'(i)) begin
        errs++; $display("FAIL abort_run[%0d] got g1b=%b cnt=%0d want 11 cnt=%0d", i, {bus.gnt1, bus.busy}, bus.cnt_out, i);
      end
    end
    bus.req1 = 0; bus.pause = 1;
    tick;
    bus.pause = 0;
    vecs++;
    if ({bus.gnt1, bus.done1, bus.busy} !== 3'b000 || bus.cnt_out !== 5'd2 || dut.rr !== 1'b0) begin
      errs++; $display("FAIL abort got g1d1b=%b cnt=%0d rr=%b want 000 cnt=2 rr=0", {bus.gnt1, bus.done1, bus.busy}, bus.cnt_out, dut.rr);
    end
    tick;
    vecs++;
    if ({bus.done0, bus.done1, bus.busy} !== 3'b000) begin
      errs++; $display("FAIL abort_after got d0d1b=%b want 000", {bus.done0, bus.done1, bus.busy});
    end
  endtask

  task automatic test_reset_mid;
    bus.req0 = 1; bus.len0 = 5'd8;
    for (int i = 0; i < 4; i++) begin
      tick;
      vecs++;
      if (bus.gnt0 !== 1'b1 || bus.cnt_out !== 5'(i)) begin
        errs++; $display("FAIL rstmid_run[%0d] got g0=%b cnt=%0d want 1 cnt=%0d", i, bus.gnt0, bus.cnt_out, i);
      end
    end
    rst = 1;
    tick;
    rst = 0; bus.req0 = 0; bus.req1 = 1; bus.len1 = 5'd2;
    vecs++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b0 || bus.cnt_out !== 5'd0 || dut.rr !== 1'b0) begin
      errs++; $display("FAIL rstmid got outs=%b cnt=%0d rr=%b want 00000 cnt=0 rr=0", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, bus.cnt_out, dut.rr);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      vecs++;
      if ({bus.gnt0, bus.gnt1, bus.done0} !== 3'b010 || bus.cnt_out !== 5'(i)) begin
        errs++; $display("FAIL rstmid_req1[%0d] got g0g1d0=%b cnt=%0d want 010 cnt=%0d", i, {bus.gnt0, bus.gnt1, bus.done0}, bus.cnt_out, i);
      end
    end
    tick;
    vecs++;
    if ({bus.gnt1, bus.done0, bus.done1} !== 3'b001) begin
      errs++; $display("FAIL rstmid_done got g1d0d1=%b want 001", {bus.gnt1, bus.done0, bus.done1});
    end
    bus.req1 = 0;
    tick;
    vecs++;
    if (bus.busy !== 1'b0) begin
      errs++; $display("FAIL rstmid_idle got busy=%b want 0", bus.busy);
    end
  endtask

  initial begin
    idle_inputs;
    test_reset;
    test_single;
    test_contention;
    test_pause;
    test_zero_abort;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/cnt_arbiter.md
CNT_ARBITER -- requirements
Module: cnt_arbiter

Interface
REQ-001 Parameter WIDTH, default 5: width of the shared counter, len0, len1 and cnt_out.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req0  input  1  requester 0 asks for a timed interval; SHALL be held high until done0 or abort.
REQ-005 req1  input  1  requester 1 asks for a timed interval; same rules as req0.
REQ-006 len0  input  WIDTH  requester 0 interval length in cycles, sampled only in the grant cycle.
REQ-007 len1  input  WIDTH  requester 1 interval length in cycles, sampled only in the grant cycle.
REQ-008 pause  input  1  freezes the running count while high.
REQ-009 gnt0  output  1  counter currently owned by requester 0.
REQ-010 gnt1  output  1  counter currently owned by requester 1.
REQ-011 done0  output  1  one-cycle pulse: requester 0 interval complete.
REQ-012 done1  output  1  one-cycle pulse: requester 1 interval complete.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 cnt_out  output  WIDTH  current value of the shared counter.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE, with a registered owner bit and a registered round-robin pointer rr.
REQ-016 IDLE, no req: hold the state; gnt0/gnt1/done0/done1 SHALL be 0.
REQ-017 IDLE, exactly one req high: grant that requester; latch its len into len_q; clear the counter to 0.
REQ-018 IDLE, both req high: grant requester rr; rr=0 selects req0, rr=1 selects req1.
REQ-019 Grant with len_q != 0: next state RUN; grant with len_q == 0: next state DONE directly, skipping RUN.
REQ-020 RUN: gnt of the owner SHALL be high and the other gnt low; both gnt SHALL be 0 in IDLE and DONE.
REQ-021 RUN, pause=1: the counter SHALL hold and the state SHALL remain RUN.
REQ-022 RUN, pause=0, count != len_q-1: the counter SHALL increment by 1.
REQ-023 RUN, pause=0, count == len_q-1: the counter SHALL hold and the next state SHALL be DONE.
REQ-024 RUN, owner req low: abort; next state IDLE, no done pulse, counter holds; abort SHALL take priority over pause and terminal count.
REQ-025 DONE: the owner's done SHALL be 1 for exactly this cycle; rr SHALL be set to the non-owner; next state IDLE.
REQ-026 Abort SHALL also set rr to the non-owner.
REQ-027 Latency: req sampled in IDLE at cycle T, len=L>0, no pause: gnt high in cycles T+1..T+L; cnt_out = 0..L-1 in those cycles; done at T+L+1; IDLE at T+L+2.
REQ-028 Counter arithmetic SHALL be WIDTH bits unsigned and SHALL never wrap, because the terminal compare stops it at len_q-1 (max 2^WIDTH-2).
REQ-029 cnt_out SHALL retain its last value through DONE and IDLE until the next grant clears it.
REQ-030 Changes on len0/len1 outside the grant cycle SHALL have no effect.
REQ-031 A req of the non-owner during RUN/DONE SHALL be ignored until the next IDLE evaluation.
REQ-032 Minimum spacing between back-to-back grants SHALL be one IDLE cycle.

Reset
REQ-033 rst=1 at posedge clk SHALL force state IDLE, rr=0, cnt_out=0, len_q=0, gnt0=gnt1=done0=done1=busy=0, regardless of state.
REQ-034 rst SHALL take priority over every other input, including mid-RUN and during the DONE cycle; no done pulse SHALL follow a reset.

Verification
REQ-035 Single request: rst, then req0=1, len0=4 at T -> gnt0 for T+1..T+4; cnt_out 0,1,2,3; done0 at T+5; busy low at T+6.
REQ-036 Contention fairness: req0=req1=1, len=2 each, held -> order gnt0, gnt1, gnt0; each done pulse occurs exactly once per interval.
REQ-037 Pause: req1, len1=3, pause=1 for 2 cycles while cnt_out=1 -> cnt_out holds 1 for those cycles; done1 arrives 2 cycles later than the no-pause case.
REQ-038 Zero length and abort: len0=0 -> done0 one cycle after grant with gnt0 never high; req1 dropped at cnt_out=2 of len1=6 -> IDLE next cycle, no done1, rr=0.
REQ-039 Reset mid-operation: rst asserted during RUN at cnt_out=3 -> next cycle all outputs 0, state IDLE, rr=0; a following req1-only request is granted normally.
